// File: rtl/gate_truth_checker_pkg.sv
// -----------------------------------------------------------------------------
// gate_check_pkg
// Shared definitions for the 2-input gate truth-table checker.
//   state_e     : sweep FSM encoding (IDLE, SETTLE, SAMPLE, DONE)
//   NUM_COMBOS  : number of input combinations of a 2-input gate
//   IDX_W       : width of the combination index
//   CNT_W       : width of the settle counter (SETTLE is at most 15)
//   mismatch()  : 4-state compare, so an X/Z gate output counts as a miss
// -----------------------------------------------------------------------------
package gate_check_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   localparam int NUM_COMBOS = 4;
   localparam int IDX_W      = 2;
   localparam int CNT_W      = 4;

   // Case inequality on purpose: a floating or unknown gate output must be
   // reported as a failure rather than silently matching.
   function automatic logic mismatch(input logic obs, input logic exp);
      return (obs !== exp);
   endfunction

endpackage

// File: rtl/gate_truth_checker_if.sv
// -----------------------------------------------------------------------------
// gate_check_if
// Bundles the request, gate-under-test and result signals of the checker.
//   start      : one-cycle sweep request          (master -> slave)
//   truth      : expected output per combination  (master -> slave)
//   gate_out   : output of the gate under test    (master -> slave)
//   in0 / in1  : gate input drive                 (slave -> master)
//   busy       : sweep in progress                (slave -> master)
//   done       : results valid                    (slave -> master)
//   pass       : done with no mismatch            (slave -> master)
//   fail_mask  : per-combination mismatch flags   (slave -> master)
// -----------------------------------------------------------------------------
interface gate_check_if;
   import gate_check_pkg::*;

   logic                  start;
   logic [NUM_COMBOS-1:0] truth;
   logic                  gate_out;
   logic                  in0;
   logic                  in1;
   logic                  busy;
   logic                  done;
   logic                  pass;
   logic [NUM_COMBOS-1:0] fail_mask;

   modport master (
      output start, truth, gate_out,
      input  in0, in1, busy, done, pass, fail_mask
   );

   modport slave (
      input  start, truth, gate_out,
      output in0, in1, busy, done, pass, fail_mask
   );

endinterface

// File: rtl/gate_truth_checker_settle_timer.sv
// -----------------------------------------------------------------------------
// settle_timer
// Counts the cycles an input combination has been held.
//   clk     : clock
//   rst     : synchronous active-high reset
//   clear   : restart the count at zero (takes priority over en)
//   en      : advance the count by one
//   expired : count has reached SETTLE-1
// -----------------------------------------------------------------------------
module settle_timer
   import gate_check_pkg::*;
#(
   parameter int SETTLE = 2
)
(
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic en,
   output logic expired
);

   logic [CNT_W-1:0] count_r;

   // Settle counter: reset/clear to zero, otherwise count while enabled.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= {CNT_W{1'b0}};
      end else if (clear) begin
         count_r <= {CNT_W{1'b0}};
      end else if (en) begin
         count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign expired = (count_r == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/gate_truth_checker.sv
// -----------------------------------------------------------------------------
// gate_truth_checker
// Sweeps a 2-input gate through combinations 00,10,01,11 (in0,in1), holds
// each for SETTLE+1 cycles and compares the gate output with the latched
// truth table on the last cycle of each combination.
//   clk   : clock, all state updates on the rising edge
//   rst   : synchronous active-high reset, dominates start
//   bus   : gate_check_if.slave (start/truth/gate_out in,
//           in0/in1/busy/done/pass/fail_mask out, all outputs registered)
// -----------------------------------------------------------------------------
module gate_truth_checker
   import gate_check_pkg::*;
#(
   parameter int SETTLE = 2
)
(
   input  logic         clk,
   input  logic         rst,
   gate_check_if.slave  bus
);

   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_SETTLE = ST_SETTLE;
   localparam logic [1:0] S_SAMPLE = ST_SAMPLE;
   localparam logic [1:0] S_DONE   = ST_DONE;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COMBOS - 1);

   generate
      if (SETTLE < 1 || SETTLE > 15) begin : g_bad_settle
         $error("gate_truth_checker: SETTLE must be in 1..15");
      end
   endgenerate

   logic [1:0]            state_r;
   logic [IDX_W-1:0]      idx_r;
   logic [NUM_COMBOS-1:0] truth_r;
   logic [NUM_COMBOS-1:0] mask_r;
   logic                  in0_r;
   logic                  in1_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  pass_r;

   logic                  accept_s;
   logic                  timer_clear_s;
   logic                  timer_en_s;
   logic                  expired_s;
   logic [NUM_COMBOS-1:0] sample_mask_s;
   logic [IDX_W-1:0]      next_idx_s;

   // Start is only honoured between sweeps; mid-sweep requests vanish.
   always_comb begin
      accept_s = 1'b0;
      if (bus.start && (state_r == S_IDLE || state_r == S_DONE)) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
   end

   // Timer runs only while settling and restarts for every combination.
   always_comb begin
      timer_en_s    = (state_r == S_SETTLE);
      timer_clear_s = accept_s || (state_r == S_SAMPLE);
   end

   // Result mask as it will look after the current combination is sampled.
   always_comb begin
      sample_mask_s         = mask_r;
      sample_mask_s[idx_r]  = mismatch(bus.gate_out, truth_r[idx_r]);
      next_idx_s            = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
   end

   settle_timer #(
      .SETTLE (SETTLE)
   ) u_settle_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (timer_clear_s),
      .en      (timer_en_s),
      .expired (expired_s)
   );

   // Sweep FSM, combination index, gate drive and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
         idx_r   <= {IDX_W{1'b0}};
         truth_r <= {NUM_COMBOS{1'b0}};
         mask_r  <= {NUM_COMBOS{1'b0}};
         in0_r   <= 1'b0;
         in1_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         pass_r  <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE, S_DONE: begin
               if (accept_s) begin
                  state_r <= S_SETTLE;
                  idx_r   <= {IDX_W{1'b0}};
                  truth_r <= bus.truth;
                  mask_r  <= {NUM_COMBOS{1'b0}};
                  in0_r   <= 1'b0;
                  in1_r   <= 1'b0;
                  busy_r  <= 1'b1;
                  done_r  <= 1'b0;
                  pass_r  <= 1'b0;
               end else begin
                  state_r <= state_r;
               end
            end
            S_SETTLE: begin
               if (expired_s) begin
                  state_r <= S_SAMPLE;
               end else begin
                  state_r <= S_SETTLE;
               end
            end
            S_SAMPLE: begin
               mask_r <= sample_mask_s;
               if (idx_r == LAST_IDX) begin
                  // idx stays at the last combination; drive returns to 00.
                  state_r <= S_DONE;
                  in0_r   <= 1'b0;
                  in1_r   <= 1'b0;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  pass_r  <= (sample_mask_s == {NUM_COMBOS{1'b0}});
               end else begin
                  state_r <= S_SETTLE;
                  idx_r   <= next_idx_s;
                  in0_r   <= next_idx_s[0];
                  in1_r   <= next_idx_s[1];
               end
            end
            default: begin
               state_r <= S_IDLE;
               idx_r   <= {IDX_W{1'b0}};
               mask_r  <= {NUM_COMBOS{1'b0}};
               in0_r   <= 1'b0;
               in1_r   <= 1'b0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               pass_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in0       = in0_r;
   assign bus.in1       = in1_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.pass      = pass_r;
   assign bus.fail_mask = mask_r;

endmodule

// File: tb/tb_gate_truth_checker.sv
// -----------------------------------------------------------------------------
// tb_gate_truth_checker
// Self-checking bench: a behavioural gate (AND/OR/stuck-0/NAND) is driven by
// the checker; expected results are queued when a sweep is requested and
// compared when done rises.
// -----------------------------------------------------------------------------
module tb_gate_truth_checker;
   import gate_check_pkg::*;

   localparam int SET = 2;
   localparam int PER = SET + 1;

   typedef struct {
      logic [3:0] mask;
      logic       pass;
   } exp_t;

   logic clk;
   logic rst;
   int   mode;
   int   n_cmp;
   int   n_err;
   exp_t sb_q[$];

   gate_check_if bus ();

   gate_truth_checker #(
      .SETTLE (SET)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // 0 = AND, 1 = OR, 2 = stuck at 0, 3 = NAND
   function automatic logic gate_fn(input int m, input logic a, input logic b);
      case (m)
         0:       return a & b;
         1:       return a | b;
         2:       return 1'b0;
         3:       return ~(a & b);
         default: return 1'b0;
      endcase
   endfunction

   assign bus.gate_out = gate_fn(mode, bus.in0, bus.in1);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_in0"},  32'(bus.in0), 32'd0);
      chk({tag, "_in1"},  32'(bus.in1), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_pass"}, 32'(bus.pass), 32'd0);
      chk({tag, "_mask"}, 32'(bus.fail_mask), 32'd0);
   endtask

   // One sweep. repulse_at / rst_at give the edge count after the accept
   // edge at which start is re-pulsed or rst asserted (-1 = never).
   task automatic sweep(input logic [3:0] t, input int mode_i,
                        input int repulse_at, input int rst_at);
      exp_t       e;
      logic [3:0] m;
      logic [3:0] k_bits;
      int         edges;
      int         combo;
      mode = mode_i;
      m = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         k_bits = 4'(k);
         m[k] = (gate_fn(mode_i, k_bits[0], k_bits[1]) != t[k]);
      end
      e.mask = m;
      e.pass = (m == 4'b0000);
      sb_q.push_back(e);

      @(negedge clk);
      bus.start = 1'b1;
      bus.truth = t;
      @(negedge clk);
      bus.start = 1'b0;
      bus.truth = ~t;
      chk("accept_busy", 32'(bus.busy), 32'd1);
      chk("accept_done", 32'(bus.done), 32'd0);
      chk("accept_pass", 32'(bus.pass), 32'd0);
      chk("accept_mask", 32'(bus.fail_mask), 32'd0);
      chk("accept_in0",  32'(bus.in0), 32'd0);
      chk("accept_in1",  32'(bus.in1), 32'd0);

      edges = 0;
      while (bus.done !== 1'b1 && edges < 200) begin
         @(negedge clk);
         edges++;
         bus.start = 1'b0;
         if (edges == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk_idle_outputs("abort");
            void'(sb_q.pop_back());
            chk("abort_sb", 32'(sb_q.size()), 32'd0);
            return;
         end
         if (bus.done !== 1'b1) begin
            combo = edges / PER;
            chk("drive_in0", 32'(bus.in0), 32'(combo & 1));
            chk("drive_in1", 32'(bus.in1), 32'((combo >> 1) & 1));
            chk("drive_busy", 32'(bus.busy), 32'd1);
            chk("mid_mask", 32'(bus.fail_mask), 32'(m & 4'((1 << combo) - 1)));
         end
         if (edges == repulse_at) begin
            bus.start = 1'b1;
            bus.truth = ~t;
         end
      end

      chk("latency", 32'(edges), 32'(4 * PER));
      if (sb_q.size() == 0) begin
         chk("sb_underflow", 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         chk("done_mask", 32'(bus.fail_mask), 32'(e.mask));
         chk("done_pass", 32'(bus.pass), 32'(e.pass));
      end
      chk("done_busy", 32'(bus.busy), 32'd0);
      chk("done_in0",  32'(bus.in0), 32'd0);
      chk("done_in1",  32'(bus.in1), 32'd0);
      // Results must hold while no new start arrives.
      @(negedge clk);
      chk("hold_done", 32'(bus.done), 32'd1);
      chk("hold_mask", 32'(bus.fail_mask), 32'(m));
   endtask

   initial begin
      n_cmp     = 0;
      n_err     = 0;
      mode      = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.truth = 4'b0000;
      repeat (2) @(negedge clk);
      chk_idle_outputs("reset");

      // rst dominates a simultaneous start.
      bus.start = 1'b1;
      bus.truth = 4'b1000;
      @(negedge clk);
      chk_idle_outputs("rst_start");
      rst       = 1'b0;
      bus.start = 1'b0;
      @(negedge clk);
      chk_idle_outputs("idle");

      sweep(4'b1000, 0, -1, -1);       // correct AND
      sweep(4'b1000, 2, -1, -1);       // stuck-at-0 output
      sweep(4'b1000, 1, -1, -1);       // OR against AND table
      sweep(4'b1000, 0, PER, -1);      // start re-pulsed in SETTLE of idx 1
      sweep(4'b1000, 2, -1, 3*PER - 1);// rst during SAMPLE of idx 2
      sweep(4'b1000, 0, -1, -1);       // fresh sweep after abort
      sweep(4'b0111, 3, -1, -1);       // restart from DONE, correct NAND

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/gate_truth_checker.md
GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

Interface
REQ-001 SETTLE, default 2, cycles each input combination is held before the output is sampled; legal range 1..15, and 0 SHALL fail elaboration.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 start  input  1  one-cycle request to run a full truth-table sweep.
REQ-005 truth  input  4  expected gate output; bit k is the expected value for combination k, and is sampled only when start is accepted.
REQ-006 gate_out  input  1  output of the 2-input gate under test.
REQ-007 in0  output  1  drives the gate's in0; equals bit 0 of the current combination index.
REQ-008 in1  output  1  drives the gate's in1; equals bit 1 of the current combination index.
REQ-009 busy  output  1  high while a sweep is in progress.
REQ-010 done  output  1  high while results are valid; stays high until the next accepted start or rst.
REQ-011 pass  output  1  equals done AND (fail_mask == 0).
REQ-012 fail_mask  output  4  bit k is set when combination k produced a mismatch.

Function
REQ-013 The block SHALL implement the FSM states IDLE, SETTLE, SAMPLE and DONE.
REQ-014 In IDLE or DONE, a start=1 SHALL be accepted, with these effects on the next edge: truth latched into truth_q, idx=0, cnt=0, fail_mask=0, done=0, busy=1, state=SETTLE.
REQ-015 A start asserted in SETTLE or SAMPLE SHALL be ignored, with no effect on any register.
REQ-016 SETTLE: cnt SHALL increment each cycle, and the FSM SHALL move to SAMPLE on the edge where cnt==SETTLE-1.
REQ-017 SAMPLE lasts exactly one cycle; on its closing edge fail_mask[idx] SHALL be set to (gate_out !== truth_q[idx]), so an X or Z input counts as a mismatch.
REQ-018 In SAMPLE with idx<3: idx SHALL increment, cnt SHALL clear, and the FSM SHALL return to SETTLE.
REQ-019 In SAMPLE with idx==3: the FSM SHALL go to DONE, busy=0 and done=1; idx SHALL NOT wrap.
REQ-020 in0/in1 SHALL equal idx[0]/idx[1] in SETTLE and SAMPLE, and 0/0 in IDLE and DONE.
REQ-021 The drive order SHALL be (in0,in1) = 00, 10, 01, 11.
REQ-022 Latency: done SHALL rise exactly 4*(SETTLE+1) edges after the start-accept edge; the inputs SHALL be held stable for SETTLE+1 cycles per combination.
REQ-023 fail_mask SHALL accumulate during the sweep and SHALL be readable mid-sweep; bits for combinations not yet sampled SHALL read 0.
REQ-024 Changes on truth after start is accepted SHALL have no effect on the current sweep.

Reset
REQ-025 rst=1 SHALL force, on the next edge: state=IDLE, idx=0, cnt=0, in0=0, in1=0, busy=0, done=0, pass=0, fail_mask=0, truth_q=0.
REQ-026 rst SHALL take priority over start, including in the same cycle.
REQ-027 rst asserted mid-sweep SHALL abort the sweep with no partial result retained.

Structure
REQ-028 The shared package gate_check_pkg SHALL hold the state enum (IDLE, SETTLE, SAMPLE, DONE), NUM_COMBOS=4 and IDX_W=2.
REQ-029 The settle counter SHALL be the sub-module settle_timer (inputs clk, rst, clear, en; output expired when count==SETTLE-1).
REQ-030 The FSM, idx register and result registers SHALL remain in gate_truth_checker.
REQ-031 Target size is 120-400 lines of RTL in total.

Verification
REQ-032 Correct AND gate: SETTLE=2, truth=4'b1000, start pulse -> in0/in1 step 00,10,01,11 for 3 cycles each; done rises 12 cycles after accept; fail_mask=0000; pass=1.
REQ-033 gate_out tied to 0: truth=4'b1000 -> fail_mask=1000, pass=0, done=1.
REQ-034 OR behaviour checked against the AND table: truth=4'b1000 -> fail_mask=0110, pass=0.
REQ-035 start re-pulsed during SETTLE of idx=1 -> ignored; done still rises at cycle 12 with the original results.
REQ-036 rst asserted during SAMPLE of idx=2 -> next cycle state=IDLE, all outputs 0; a new start then completes normally in 12 cycles.
REQ-037 Restart from DONE with truth=4'b0111 on a correct NAND gate -> done drops on the accept edge, then rises with pass=1 and fail_mask=0000.
